// File: rtl/wrr_rank_enqueue.sv
// Re-attaches buffer addresses to WRR engine ranks and queues {rank,addr} entries for the PIFO.
// Optional statistics counters are built only when WRR_RANK_STATS_EN is defined.
module wrr_rank_enqueue #(
    parameter int unsigned RESULT_WIDTH    = 32,
    parameter int unsigned PIFO_ADDR_WIDTH = 12,
    parameter int unsigned ENGINE_LATENCY  = 3,
    parameter int unsigned FIFO_AW         = 4,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       desc_valid_i,
    input  logic [PIFO_ADDR_WIDTH-1:0] desc_addr_i,
    input  logic                       rank_valid_i,
    input  logic [RESULT_WIDTH-1:0]    rank_data_i,
    output logic                       ins_valid_o,
    output logic [RESULT_WIDTH-1:0]    ins_data_o,
    input  logic                       ins_ready_i,
    output logic [FIFO_AW:0]           fifo_level_o,
    output logic                       drop_sticky_o,
    output logic                       align_err_o,
    output logic [CNT_WIDTH-1:0]       stat_enq_cnt_o,
    output logic [CNT_WIDTH-1:0]       stat_drop_cnt_o
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned DlW   = PIFO_ADDR_WIDTH + 1;

    logic [DlW-1:0]             dl_q [ENGINE_LATENCY];
    logic [RESULT_WIDTH-1:0]    mem_q [Depth];
    logic [FIFO_AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]           level_q, level_d;
    logic                       drop_q, align_err_q;

    logic                       d_v;
    logic [PIFO_ADDR_WIDTH-1:0] d_addr;
    logic [RESULT_WIDTH-1:0]    merged;
    logic                       empty, full, pop, push, drop;
    logic                       unused_rank_lo;

    assign d_v    = dl_q[ENGINE_LATENCY-1][DlW-1];
    assign d_addr = dl_q[ENGINE_LATENCY-1][PIFO_ADDR_WIDTH-1:0];
    // Rank low bits are placeholders from the engine and get replaced by the address.
    assign merged = {rank_data_i[RESULT_WIDTH-1:PIFO_ADDR_WIDTH], d_addr};
    assign unused_rank_lo = ^rank_data_i[PIFO_ADDR_WIDTH-1:0];

    assign empty = (level_q == '0);
    // Level never exceeds Depth, so the top bit alone flags full.
    assign full  = level_q[FIFO_AW];
    assign pop   = !empty && ins_ready_i;
    assign push  = rank_valid_i && (!full || pop);
    assign drop  = rank_valid_i && full && !pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENGINE_LATENCY; i++) dl_q[i] <= '0;
        end else begin
            dl_q[0] <= {desc_valid_i, desc_addr_i};
            for (int i = 1; i < ENGINE_LATENCY; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= merged;
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_q      <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            level_q <= level_d;
            if (drop) drop_q <= 1'b1;
            if (rank_valid_i != d_v) align_err_q <= 1'b1;
        end
    end

`ifdef WRR_RANK_STATS_EN
    logic [CNT_WIDTH-1:0] enq_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            enq_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && enq_cnt_q != '1)  enq_cnt_q  <= enq_cnt_q + CNT_WIDTH'(1);
            if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stat_enq_cnt_o  = enq_cnt_q;
    assign stat_drop_cnt_o = drop_cnt_q;
`else
    assign stat_enq_cnt_o  = '0;
    assign stat_drop_cnt_o = '0;
`endif

    assign ins_valid_o   = !empty;
    assign ins_data_o    = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level_o  = level_q;
    assign drop_sticky_o = drop_q;
    assign align_err_o   = align_err_q;

endmodule

// File: tb/tb_wrr_rank_enqueue.sv
// Self-checking bench for wrr_rank_enqueue: directed tables and sequences plus a randomized run
// against a queue-based reference model.
module tb_wrr_rank_enqueue;

    localparam int RW    = 32;
    localparam int AW    = 12;
    localparam int LAT   = 3;
    localparam int FAW   = 4;
    localparam int CW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          desc_valid;
    logic [AW-1:0] desc_addr;
    logic          rank_valid;
    logic [RW-1:0] rank_data;
    logic          ins_valid;
    logic [RW-1:0] ins_data;
    logic          ins_ready;
    logic [FAW:0]  fifo_level;
    logic          drop_sticky;
    logic          align_err;
    logic [CW-1:0] stat_enq_cnt;
    logic [CW-1:0] stat_drop_cnt;

    always #5 clk = ~clk;

    wrr_rank_enqueue #(
        .RESULT_WIDTH(RW), .PIFO_ADDR_WIDTH(AW), .ENGINE_LATENCY(LAT),
        .FIFO_AW(FAW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .desc_valid_i(desc_valid), .desc_addr_i(desc_addr),
        .rank_valid_i(rank_valid), .rank_data_i(rank_data),
        .ins_valid_o(ins_valid), .ins_data_o(ins_data), .ins_ready_i(ins_ready),
        .fifo_level_o(fifo_level), .drop_sticky_o(drop_sticky), .align_err_o(align_err),
        .stat_enq_cnt_o(stat_enq_cnt), .stat_drop_cnt_o(stat_drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: descriptors in flight, buffered entries, sticky flags, counters.
    logic [RW-1:0] mq[$];
    logic [AW:0]   mdl[$];
    bit            m_drop, m_aerr;
    longint        m_enq, m_dropc;

    typedef struct {
        logic          dv;
        logic [AW-1:0] da;
        logic          rv;
        logic [RW-1:0] rd;
        logic          rdy;
        logic          ev;
        logic [RW-1:0] ed;
        logic [FAW:0]  el;
    } vec_t;

    vec_t s1 [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] cnt_exp(input longint v);
`ifdef WRR_RANK_STATS_EN
        return v;
`else
        return (v == 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        mdl.delete();
        for (int i = 0; i < LAT; i++) mdl.push_back('0);
        m_drop  = 0;
        m_aerr  = 0;
        m_enq   = 0;
        m_dropc = 0;
    endtask

    task automatic check_model();
        chk("ins_valid", ins_valid, mq.size() != 0);
        chk("ins_data", ins_data, (mq.size() != 0) ? mq[0] : '0);
        chk("fifo_level", fifo_level, mq.size());
        chk("drop_sticky", drop_sticky, m_drop);
        chk("align_err", align_err, m_aerr);
        chk("stat_enq_cnt", stat_enq_cnt, cnt_exp(m_enq));
        chk("stat_drop_cnt", stat_drop_cnt, cnt_exp(m_dropc));
    endtask

    // Check the current cycle, advance the model with the driven inputs, then clock.
    task automatic tick();
        logic [AW:0] tail;
        bit          pop, was_full;
        check_model();
        if (!rstn) begin
            model_reset();
        end else begin
            tail     = mdl[0];
            pop      = (mq.size() != 0) && ins_ready;
            was_full = (mq.size() == DEPTH);
            if (rank_valid != tail[AW]) m_aerr = 1;
            if (pop) void'(mq.pop_front());
            if (rank_valid) begin
                if (!was_full || pop) begin
                    mq.push_back({rank_data[RW-1:AW], tail[AW-1:0]});
                    if (m_enq < 64'hFFFF_FFFF) m_enq++;
                end else begin
                    m_drop = 1;
                    if (m_dropc < 64'hFFFF_FFFF) m_dropc++;
                end
            end
            void'(mdl.pop_front());
            mdl.push_back({desc_valid, desc_addr});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        desc_valid = 0;
        desc_addr  = '0;
        rank_valid = 0;
        rank_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        tick();
        rstn = 1;
    endtask

    task automatic run_s1();
        for (int i = 0; i < 7; i++) begin
            desc_valid = s1[i].dv;
            desc_addr  = s1[i].da;
            rank_valid = s1[i].rv;
            rank_data  = s1[i].rd;
            ins_ready  = s1[i].rdy;
            chk($sformatf("s1_valid[%0d]", i), ins_valid, s1[i].ev);
            chk($sformatf("s1_data[%0d]", i), ins_data, s1[i].ed);
            chk($sformatf("s1_level[%0d]", i), fifo_level, s1[i].el);
            tick();
        end
        chk("s1_align_err", align_err, 0);
    endtask

    initial begin
        s1[0] = '{1'b1, 12'h0A5, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0};
        s1[1] = '{1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0};
        s1[2] = '{1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0};
        s1[3] = '{1'b0, 12'h000, 1'b1, 32'h8001_2000, 1'b1, 1'b0, 32'h0, 5'd0};
        s1[4] = '{1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8001_20A5, 5'd1};
        s1[5] = '{1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0};
        s1[6] = '{1'b0, 12'h000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 5'd0};

        idle();
        ins_ready = 0;
        rstn      = 0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        tick();
        rstn = 1;

        // Single request latency.
        run_s1();

        // Overflow with ready held low.
        ins_ready = 0;
        for (int k = 0; k < 17 + LAT; k++) begin
            desc_valid = (k < 17);
            desc_addr  = AW'($urandom);
            rank_valid = (k >= LAT) && (k < 17 + LAT);
            rank_data  = $urandom;
            tick();
        end
        idle();
        chk("s2_level", fifo_level, 16);
        chk("s2_drop_sticky", drop_sticky, 1);
        chk("s2_enq_cnt", stat_enq_cnt, cnt_exp(16));
        chk("s2_drop_cnt", stat_drop_cnt, cnt_exp(1));

        // Push and pop together while full.
        desc_valid = 1;
        desc_addr  = 12'h3C3;
        tick();
        idle();
        for (int k = 1; k < LAT; k++) tick();
        rank_valid = 1;
        rank_data  = 32'hC0DE_0000;
        ins_ready  = 1;
        tick();
        idle();
        ins_ready = 0;
        chk("s3_level", fifo_level, 16);
        chk("s3_drop_cnt", stat_drop_cnt, cnt_exp(1));
        chk("s3_enq_cnt", stat_enq_cnt, cnt_exp(17));
        ins_ready = 1;
        for (int k = 0; k < 20; k++) tick();
        chk("s3_drained", fifo_level, 0);

        // Rank without descriptor, then descriptor without rank.
        do_reset();
        rank_valid = 1;
        rank_data  = 32'hA5A5_5A5A;
        tick();
        idle();
        chk("s4a_align_err", align_err, 1);
        chk("s4a_level", fifo_level, 1);
        for (int k = 0; k < 3; k++) tick();
        do_reset();
        desc_valid = 1;
        desc_addr  = 12'h777;
        tick();
        idle();
        for (int k = 0; k < LAT; k++) tick();
        chk("s4b_align_err", align_err, 1);

        // Reset with a partly filled FIFO.
        do_reset();
        ins_ready = 0;
        for (int k = 0; k < 10 + LAT; k++) begin
            desc_valid = (k < 10);
            desc_addr  = AW'($urandom);
            rank_valid = (k >= LAT);
            rank_data  = $urandom;
            tick();
        end
        idle();
        chk("s5_prefill", fifo_level, 10);
        do_reset();
        chk("s5_valid", ins_valid, 0);
        chk("s5_level", fifo_level, 0);
        chk("s5_enq_cnt", stat_enq_cnt, 0);
        run_s1();

        // 40-entry stream with ready toggling.
        do_reset();
        for (int k = 0; k < 80 + LAT + 4; k++) begin
            desc_valid = (k % 2 == 0) && (k < 80);
            desc_addr  = AW'($urandom);
            rank_valid = (k >= LAT) && ((k - LAT) % 2 == 0) && (k - LAT < 80);
            rank_data  = $urandom;
            ins_ready  = (k % 2 == 0);
            tick();
        end
        idle();
        ins_ready = 1;
        for (int k = 0; k < 4; k++) tick();
        chk("s6_enq_cnt", stat_enq_cnt, cnt_exp(40));
        chk("s6_drop_sticky", drop_sticky, 0);
        chk("s6_level", fifo_level, 0);

        // Randomized traffic with occasional misalignment.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            logic [AW:0] tail;
            tail       = mdl[0];
            desc_valid = $urandom_range(0, 1) == 1;
            desc_addr  = AW'($urandom);
            rank_valid = ($urandom_range(0, 49) == 0) ? !tail[AW] : tail[AW];
            rank_data  = $urandom;
            ins_ready  = $urandom_range(0, 2) == 0;
            tick();
        end
        idle();
        ins_ready = 1;
        for (int k = 0; k < 20; k++) tick();
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
